// File: rtl/resp_analyzer_pkg.sv
// Shared types and default constants for the response analyzer (MISR compactor).
package resp_analyzer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;
  localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

endpackage

// File: rtl/misr_step.sv
// One combinational MISR step: shift left, fold the top bit through POLY, xor in the response.
module misr_step
  import resp_analyzer_pkg::*;
#(
  parameter int unsigned        SIG_W  = 16,
  parameter int unsigned        RESP_W = 2,
  parameter logic [SIG_W-1:0]   POLY   = SIG_W'(DEFAULT_POLY)
) (
  input  logic [SIG_W-1:0]  sig,
  input  logic [RESP_W-1:0] resp,
  output logic [SIG_W-1:0]  next_sig_c
);

  always_comb begin
    next_sig_c = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
  end

endmodule

// File: rtl/resp_analyzer.sv
// Response analyzer: compacts N_PATTERNS response words into a MISR signature and
// compares the final signature against GOLDEN.
module resp_analyzer
  import resp_analyzer_pkg::*;
#(
  parameter int unsigned      RESP_W     = 2,
  parameter int unsigned      SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED       = SIG_W'(DEFAULT_SEED),
  parameter int unsigned      N_PATTERNS = 16,
  parameter logic [SIG_W-1:0] GOLDEN     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iStart,
  input  logic              iValid,
  input  logic [RESP_W-1:0] iResp,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPass,
  output logic [SIG_W-1:0]  oSignature,
  output logic [SIG_W-1:0]  oCount
);

  localparam logic [SIG_W-1:0] LAST_IDX = SIG_W'(N_PATTERNS - 1);

  state_t           state, state_d;
  logic [SIG_W-1:0] sig_d, count_d, step_c;
  logic             busy_d, done_d, pass_d;

  misr_step #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY)
  ) u_misr_step (
    .sig        (oSignature),
    .resp       (iResp),
    .next_sig_c (step_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and next output values; busy/done are decoded from the next state
  // so the flags line up with the registered state.
  always_comb begin
    state_d = state;
    sig_d   = oSignature;
    count_d = oCount;
    pass_d  = oPass;
    unique case (state)
      IDLE, DONE: begin
        if (iStart) begin
          state_d = COLLECT;
          sig_d   = SEED;
          count_d = '0;
          pass_d  = 1'b0;
        end
      end
      COLLECT: begin
        if (iValid) begin
          sig_d   = step_c;
          count_d = oCount + SIG_W'(1);
          if (oCount == LAST_IDX) begin
            state_d = DONE;
            pass_d  = (step_c == GOLDEN);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COLLECT);
    done_d = (state_d == DONE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oPass      <= 1'b0;
      oSignature <= SEED;
      oCount     <= '0;
    end else begin
      oBusy      <= busy_d;
      oDone      <= done_d;
      oPass      <= pass_d;
      oSignature <= sig_d;
      oCount     <= count_d;
    end
  end

endmodule

// File: tb/tb_resp_analyzer.sv
// Self-checking bench for resp_analyzer: three instances sharing stimulus, checked each cycle
// against a behavioural model, plus directed literal expectations.
module tb_resp_analyzer;

  // Gate DUT response for a 4-bit input: {AND of low pair, OR of high pair}
  function automatic logic [1:0] gate(input logic [3:0] v);
    return {v[0] & v[1], v[2] | v[3]};
  endfunction

  // MISR as polynomial arithmetic: multiply by x, reduce mod x^16+x^12+x^5+1, add response
  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [1:0] r);
    logic [16:0] w;
    w = {s, 1'b0};
    if (w[16]) w = w ^ 17'h11021;
    return w[15:0] ^ {14'b0, r};
  endfunction

  function automatic logic [15:0] gate_sig();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < 16; i++) s = misr_ref(s, gate(4'(i)));
    return s;
  endfunction

  localparam logic [15:0] GOLD_GATE = gate_sig();

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  resp = 2'b00;
  logic        busy [3];
  logic        done [3];
  logic        pass [3];
  logic [15:0] sig  [3];
  logic [15:0] cnt  [3];

  int total = 0;
  int bad = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  resp_analyzer #(.N_PATTERNS(16), .GOLDEN(GOLD_GATE)) dut_a (
    .clk(clk), .rst_n(rst_n), .iStart(start), .iValid(valid), .iResp(resp),
    .oBusy(busy[0]), .oDone(done[0]), .oPass(pass[0]), .oSignature(sig[0]), .oCount(cnt[0]));

  resp_analyzer #(.N_PATTERNS(16), .GOLDEN(GOLD_GATE ^ 16'h0001)) dut_b (
    .clk(clk), .rst_n(rst_n), .iStart(start), .iValid(valid), .iResp(resp),
    .oBusy(busy[1]), .oDone(done[1]), .oPass(pass[1]), .oSignature(sig[1]), .oCount(cnt[1]));

  resp_analyzer #(.N_PATTERNS(1), .GOLDEN(16'h0000)) dut_c (
    .clk(clk), .rst_n(rst_n), .iStart(start), .iValid(valid), .iResp(resp),
    .oBusy(busy[2]), .oDone(done[2]), .oPass(pass[2]), .oSignature(sig[2]), .oCount(cnt[2]));

  // Behavioural model: phase 0 = idle, 1 = collecting, 2 = finished
  int          m_ph   [3] = '{0, 0, 0};
  logic [15:0] m_sig  [3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
  logic [15:0] m_cnt  [3] = '{16'h0, 16'h0, 16'h0};
  logic        m_pass [3] = '{1'b0, 1'b0, 1'b0};
  int          m_n    [3] = '{16, 16, 1};
  logic [15:0] m_gold [3] = '{GOLD_GATE, GOLD_GATE ^ 16'h0001, 16'h0000};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_ph[k] <= 0; m_sig[k] <= 16'hFFFF; m_cnt[k] <= 16'h0; m_pass[k] <= 1'b0;
      end else if (m_ph[k] != 1) begin
        if (start) begin
          m_ph[k] <= 1; m_sig[k] <= 16'hFFFF; m_cnt[k] <= 16'h0; m_pass[k] <= 1'b0;
        end
      end else if (valid) begin
        m_sig[k] <= misr_ref(m_sig[k], resp);
        m_cnt[k] <= m_cnt[k] + 16'd1;
        if (int'(m_cnt[k]) + 1 == m_n[k]) begin
          m_ph[k]   <= 2;
          m_pass[k] <= (misr_ref(m_sig[k], resp) == m_gold[k]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_ph[k] == 1));
        chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_ph[k] == 2));
        chk($sformatf("pass%0d", k), 32'(pass[k]), 32'(m_pass[k]));
        chk($sformatf("sig%0d", k),  32'(sig[k]),  32'(m_sig[k]));
        chk($sformatf("cnt%0d", k),  32'(cnt[k]),  32'(m_cnt[k]));
      end
    end
  end

  // Drive one cycle of inputs (called just after a rising edge) and return after the next edge
  task automatic cyc(input logic st, input logic v, input logic [1:0] r);
    start = st; valid = v; resp = r;
    @(posedge clk);
    #1;
  endtask

  task automatic gate_run(input bit do_start);
    if (do_start) cyc(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) cyc(1'($urandom_range(0, 1)), 1'b0, 2'($urandom));
      cyc(1'b0, 1'b1, gate(4'(i)));
    end
    chk("gate_done", 32'(done[0]), 32'd1);
    chk("gate_cnt", 32'(cnt[0]), 32'd16);
    chk("gate_sig", 32'(sig[0]), 32'(GOLD_GATE));
    chk("gate_pass", 32'(pass[0]), 32'd1);
    chk("gate_badgold_pass", 32'(pass[1]), 32'd0);
    chk("gate_badgold_done", 32'(done[1]), 32'd1);
  endtask

  initial begin
    #1;
    rst_n = 1'b0; valid = 1'b1; start = 1'b1; resp = 2'b11;
    #1 en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig", 32'(sig[0]), 32'h0000FFFF);
    chk("rst_cnt", 32'(cnt[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_pass", 32'(pass[0]), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 2'b00);

    // Single-response runs on the N_PATTERNS=1 instance
    cyc(1'b1, 1'b0, 2'b00);
    chk("start_busy", 32'(busy[2]), 32'd1);
    cyc(1'b0, 1'b1, 2'b00);
    chk("one_sig00", 32'(sig[2]), 32'h0000EFDF);
    chk("one_done00", 32'(done[2]), 32'd1);
    cyc(1'b1, 1'b0, 2'b00);
    chk("one_redone", 32'(done[2]), 32'd0);
    cyc(1'b0, 1'b1, 2'b11);
    chk("one_sig11", 32'(sig[2]), 32'h0000EFDC);

    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 2'b00);

    // Exhaustive gate run with gaps and stray starts, then ignored valids in DONE
    gate_run(1'b1);
    repeat (3) cyc(1'b0, 1'b1, 2'($urandom));
    chk("done_hold_cnt", 32'(cnt[0]), 32'd16);
    chk("done_hold_sig", 32'(sig[0]), 32'(GOLD_GATE));

    // Back-to-back run
    cyc(1'b1, 1'b0, 2'b00);
    chk("b2b_done", 32'(done[0]), 32'd0);
    chk("b2b_sig", 32'(sig[0]), 32'h0000FFFF);
    gate_run(1'b0);

    // Mid-run reset after 7 responses
    cyc(1'b1, 1'b0, 2'b00);
    repeat (7) cyc(1'b0, 1'b1, 2'($urandom));
    chk("mid_cnt", 32'(cnt[0]), 32'd7);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sig", 32'(sig[0]), 32'h0000FFFF);
    chk("mid_rst_cnt", 32'(cnt[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_done", 32'(done[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gate_run(1'b1);

    // Random traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom));
        rst_n = 1'b1;
      end
      cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0), 2'($urandom));
    end

    cyc(1'b0, 1'b0, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
